// File: rtl/binary_bbox_tracker.sv
// Bounding-box and foreground-count tracker for binarized video frames.
// Publishes box, count and found flag with a one-cycle strobe at each frame end.
module binary_bbox_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [9:0]  iDATA,
    output logic [11:0] oX_MIN,
    output logic [11:0] oX_MAX,
    output logic [11:0] oY_MIN,
    output logic [11:0] oY_MAX,
    output logic [23:0] oCOUNT,
    output logic        oFOUND,
    output logic        oVALID
);

    typedef enum logic [1:0] {SYNC, IDLE, ACTIVE} state_t;

    localparam logic [11:0] X_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LIM   = 12'(V_ACTIVE);
    localparam logic [23:0] MIN_CNT = 24'(MIN_PIXELS);

    state_t      state_q, state_d;
    logic        fval_q, fval_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [23:0] cnt_q, cnt_d;
    logic [11:0] x_min_q, x_min_d, x_max_q, x_max_d;
    logic [11:0] y_min_q, y_min_d, y_max_q, y_max_d;
    logic [11:0] ox_min_q, ox_min_d, ox_max_q, ox_max_d;
    logic [11:0] oy_min_q, oy_min_d, oy_max_q, oy_max_d;
    logic [23:0] ocount_q, ocount_d;
    logic        ofound_q, ofound_d;
    logic        ovalid_q, ovalid_d;
    logic        take;
    logic        fg;

    assign fg = |iDATA;

    always_comb begin
        state_d  = state_q;
        fval_d   = iFVAL;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        x_min_d  = x_min_q;
        x_max_d  = x_max_q;
        y_min_d  = y_min_q;
        y_max_d  = y_max_q;
        ox_min_d = ox_min_q;
        ox_max_d = ox_max_q;
        oy_min_d = oy_min_q;
        oy_max_d = oy_max_q;
        ocount_d = ocount_q;
        ofound_d = ofound_q;
        ovalid_d = 1'b0;
        take     = 1'b0;

        case (state_q)
            SYNC: begin
                if (!iFVAL) state_d = IDLE;
            end
            IDLE: begin
                // A pixel arriving with the frame rise is processed against the cleared values.
                if (iFVAL) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    x_min_d = '1;
                    x_max_d = '0;
                    y_min_d = '1;
                    y_max_d = '0;
                    take    = iDVAL;
                end
            end
            ACTIVE: begin
                if (!iFVAL && fval_q) begin
                    state_d  = IDLE;
                    ovalid_d = 1'b1;
                    ocount_d = cnt_q;
                    if (cnt_q >= MIN_CNT) begin
                        ofound_d = 1'b1;
                        ox_min_d = x_min_q;
                        ox_max_d = x_max_q;
                        oy_min_d = y_min_q;
                        oy_max_d = y_max_q;
                    end else begin
                        ofound_d = 1'b0;
                        ox_min_d = '0;
                        ox_max_d = '0;
                        oy_min_d = '0;
                        oy_max_d = '0;
                    end
                end else begin
                    take = iDVAL && iFVAL;
                end
            end
            default: state_d = SYNC;
        endcase

        // Accumulate on the pre-increment coordinate, then advance the position.
        if (take) begin
            if (fg && (y_d < Y_LIM)) begin
                if (cnt_d != '1) cnt_d = cnt_d + 24'd1;
                if (x_d < x_min_d) x_min_d = x_d;
                if (x_d > x_max_d) x_max_d = x_d;
                if (y_d < y_min_d) y_min_d = y_d;
                if (y_d > y_max_d) y_max_d = y_d;
            end
            if (x_d == X_LAST) begin
                x_d = '0;
                if (y_d != Y_LIM) y_d = y_d + 12'd1;
            end else begin
                x_d = x_d + 12'd1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q  <= SYNC;
            fval_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            x_min_q  <= '1;
            x_max_q  <= '0;
            y_min_q  <= '1;
            y_max_q  <= '0;
            ox_min_q <= '0;
            ox_max_q <= '0;
            oy_min_q <= '0;
            oy_max_q <= '0;
            ocount_q <= '0;
            ofound_q <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fval_q   <= fval_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            x_min_q  <= x_min_d;
            x_max_q  <= x_max_d;
            y_min_q  <= y_min_d;
            y_max_q  <= y_max_d;
            ox_min_q <= ox_min_d;
            ox_max_q <= ox_max_d;
            oy_min_q <= oy_min_d;
            oy_max_q <= oy_max_d;
            ocount_q <= ocount_d;
            ofound_q <= ofound_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign oX_MIN = ox_min_q;
    assign oX_MAX = ox_max_q;
    assign oY_MIN = oy_min_q;
    assign oY_MAX = oy_max_q;
    assign oCOUNT = ocount_q;
    assign oFOUND = ofound_q;
    assign oVALID = ovalid_q;

endmodule

// File: tb/tb_binary_bbox_tracker.sv
// Directed-vector bench for binary_bbox_tracker on an 8x6 frame, MIN_PIXELS=4.
// Pixel masks are indexed y*8+x; expected results are hand-computed per frame.
module tb_binary_bbox_tracker;

    localparam int H = 8;
    localparam int V = 6;
    localparam int MINP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fval;
    logic        dval;
    logic [9:0]  data;
    logic [11:0] x_min, x_max, y_min, y_max;
    logic [23:0] count;
    logic        found;
    logic        valid;

    int vectors = 0;
    int errors  = 0;
    int pulses  = 0;
    int p0;

    always #5 clk = ~clk;

    binary_bbox_tracker #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .MIN_PIXELS(MINP)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst_n),
        .iFVAL (fval),
        .iDVAL (dval),
        .iDATA (data),
        .oX_MIN(x_min),
        .oX_MAX(x_max),
        .oY_MIN(y_min),
        .oY_MAX(y_max),
        .oCOUNT(count),
        .oFOUND(found),
        .oVALID(valid)
    );

    always @(negedge clk) if (valid === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rect(input int x0, input int x1, input int y0, input int y1);
        logic [63:0] m;
        m = '0;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                m[y*H + x] = 1'b1;
        return m;
    endfunction

    task automatic check_outputs(input string tag, input int ex0, input int ex1, input int ey0,
                                 input int ey1, input int ecnt, input bit efound);
        check({tag, "_x_min"}, 32'(x_min), 32'(ex0));
        check({tag, "_x_max"}, 32'(x_max), 32'(ex1));
        check({tag, "_y_min"}, 32'(y_min), 32'(ey0));
        check({tag, "_y_max"}, 32'(y_max), 32'(ey1));
        check({tag, "_count"}, 32'(count), 32'(ecnt));
        check({tag, "_found"}, 32'(found), 32'(efound));
    endtask

    task automatic run_frame(input string tag, input logic [63:0] mask, input int npix,
                             input bit gapped, input bit early,
                             input int ex0, input int ex1, input int ey0, input int ey1,
                             input int ecnt, input bit efound);
        bit first;
        first = 1'b1;
        fval  = 1'b1;
        if (!early) begin
            dval = 1'b0;
            data = '0;
            tick();
            check({tag, "_valid_idle"}, 32'(valid), 32'd0);
            first = 1'b0;
        end
        for (int i = 0; i < npix; i++) begin
            dval = 1'b1;
            data = mask[i] ? 10'h3FF : 10'h000;
            tick();
            if (first) check({tag, "_valid_idle"}, 32'(valid), 32'd0);
            first = 1'b0;
            if (gapped) begin
                dval = 1'b0;
                data = '0;
                tick();
            end
        end
        fval = 1'b0;
        dval = 1'b0;
        data = '0;
        tick();
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check_outputs(tag, ex0, ex1, ey0, ey1, ecnt, efound);
    endtask

    initial begin
        logic [63:0] m;
        rst_n = 1'b0;
        fval  = 1'b0;
        dval  = 1'b0;
        data  = '0;
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check_outputs("rst", 0, 0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single blob, columns 2-4 of rows 1-3.
        p0 = pulses;
        run_frame("blob", rect(2, 4, 1, 3), 48, 1'b0, 1'b0, 2, 4, 1, 3, 9, 1'b1);
        tick();
        check("blob_valid_drop", 32'(valid), 32'd0);
        check("blob_hold_count", 32'(count), 32'd9);
        check("blob_pulses", 32'(pulses - p0), 32'd1);

        // Below threshold: report count, zero box.
        m = '0;
        m[5*H + 7] = 1'b1;
        m[0] = 1'b1;
        m[2*H + 5] = 1'b1;
        run_frame("below", m, 48, 1'b0, 1'b0, 0, 0, 0, 0, 3, 1'b0);
        tick();

        // Gapped iDVAL, first pixel with the iFVAL rise.
        m = '0;
        m[0] = 1'b1;
        m[3*H + 3] = 1'b1;
        m[3*H + 4] = 1'b1;
        m[5*H + 7] = 1'b1;
        run_frame("gapped", m, 48, 1'b1, 1'b1, 0, 7, 0, 5, 4, 1'b1);
        tick();

        // Overlong frame: rows past 5 are ignored.
        run_frame("overlong", '1, 60, 1'b0, 1'b0, 0, 7, 0, 5, 48, 1'b1);
        tick();

        // Reset mid-frame; the interrupted frame must never publish.
        p0 = pulses;
        fval = 1'b1;
        dval = 1'b1;
        data = 10'h3FF;
        for (int i = 0; i < 20; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", 32'(valid), 32'd0);
        check_outputs("midrst", 0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        fval = 1'b0;
        dval = 1'b0;
        data = '0;
        tick();
        tick();
        check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        check("midrst_count_hold", 32'(count), 32'd0);
        run_frame("postrst", rect(2, 4, 1, 3), 48, 1'b0, 1'b0, 2, 4, 1, 3, 9, 1'b1);
        tick();

        // Back-to-back frames with a single low iFVAL cycle.
        p0 = pulses;
        run_frame("b2b_a", rect(1, 2, 1, 2), 48, 1'b0, 1'b0, 1, 2, 1, 2, 4, 1'b1);
        run_frame("b2b_b", rect(5, 6, 4, 5), 48, 1'b0, 1'b0, 5, 6, 4, 5, 4, 1'b1);
        tick();
        check("b2b_pulses", 32'(pulses - p0), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
